// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
// Latency: accept cycle, one EXEC cycle, then response; 3 cycles minimum per op.
// Backpressure: one op in flight; new requests wait until the response handshake.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [3:0]        rsp_flags,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_flags,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state_q, state_d;
  logic               owner_q;
  logic               last_grant_q;
  logic [DATA_W-1:0]  a_q, b_q;
  logic [OP_W-1:0]    op_q;
  logic [DATA_W-1:0]  result_q;
  logic [3:0]         flags_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               grant_vld;
  logic               grant;
  logic               accept;
  logic               rsp_done;

  // Round-robin grant: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    grant_vld = 1'b0;
    grant     = 1'b0;
    case (req_valid)
      2'b01:   begin grant_vld = 1'b1; grant = 1'b0;          end
      2'b10:   begin grant_vld = 1'b1; grant = 1'b1;          end
      2'b11:   begin grant_vld = 1'b1; grant = ~last_grant_q; end
      default: begin grant_vld = 1'b0; grant = 1'b0;          end
    endcase
  end

  // Reset gates acceptance so nothing is committed while reset is asserted.
  assign accept   = (state_q == IDLE) && grant_vld && !reset;
  assign rsp_done = (state_q == RESP) && rsp_ready[owner_q];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: IDLE -> EXEC on accept, EXEC always one cycle, RESP waits for the owner.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)   state_d = EXEC;
      EXEC:                  state_d = RESP;
      RESP:    if (rsp_done) state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    busy      = (state_q != IDLE);
    if (accept)            req_ready[grant]   = 1'b1;
    if (state_q == RESP)   rsp_valid[owner_q] = 1'b1;
  end

  // Operand capture, result capture, fairness pointer and completion counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      result_q     <= '0;
      flags_q      <= '0;
      cnt_q        <= '0;
    end else begin
      if (accept) begin
        a_q     <= grant ? req1_a  : req0_a;
        b_q     <= grant ? req1_b  : req0_b;
        op_q    <= grant ? req1_op : req0_op;
        owner_q <= grant;
      end
      if (state_q == EXEC) begin
        result_q <= alu_result;
        flags_q  <= alu_flags;
      end
      if (rsp_done) begin
        last_grant_q <= owner_q;
        cnt_q        <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Operand registers drive the ALU directly and hold until the next accept.
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_ctrl   = op_q;
  assign rsp_result = result_q;
  assign rsp_flags  = flags_q;
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios, then random traffic against a
// transaction-level reference. A behavioural ALU closes the loop around the DUT;
// a second instance with a 2-bit counter exercises counter wrap.
module tb_alu_arbiter;

  localparam int DW = 32;
  localparam int OW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_valid, rsp_ready;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [OW-1:0] req0_op, req1_op;

  logic [1:0]    req_ready, rsp_valid;
  logic [DW-1:0] rsp_result, alu_a, alu_b, alu_result;
  logic [3:0]    rsp_flags, alu_flags;
  logic [OW-1:0] alu_ctrl;
  logic          busy;
  logic [15:0]   op_count;

  logic [1:0]    req_ready2, rsp_valid2;
  logic [DW-1:0] rsp_result2, alu_a2, alu_b2, alu_result2;
  logic [3:0]    rsp_flags2, alu_flags2;
  logic [OW-1:0] alu_ctrl2;
  logic          busy2;
  logic [1:0]    op_count2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(DW), .OP_W(OW), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_flags(alu_flags), .busy(busy), .op_count(op_count)
  );

  alu_arbiter #(.DATA_W(DW), .OP_W(OW), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready2),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_result(rsp_result2), .rsp_flags(rsp_flags2),
    .alu_a(alu_a2), .alu_b(alu_b2), .alu_ctrl(alu_ctrl2),
    .alu_result(alu_result2), .alu_flags(alu_flags2), .busy(busy2), .op_count(op_count2)
  );

  // Behavioural ALU: returns {result, N, Z, C, V}; C on subtract means "no borrow".
  function automatic logic [DW+3:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [OW-1:0] op);
    logic [DW:0]   s;
    logic [DW-1:0] r;
    logic          c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[DW-1:0]; c = s[DW];
                  v = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]); end
      3'd1: begin r = a - b; c = (a >= b);
                  v = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ($signed(a) < $signed(b)) ? a : b;
      default: r = '0;
    endcase
    return {r, r[DW-1], (r == '0), c, v};
  endfunction

  assign {alu_result,  alu_flags}  = alu_f(alu_a,  alu_b,  alu_ctrl);
  assign {alu_result2, alu_flags2} = alu_f(alu_a2, alu_b2, alu_ctrl2);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference-model state for the random phase.
  logic          m_busy;
  int            m_age;
  logic          m_owner, m_last;
  int            m_cnt;
  logic [DW-1:0] m_a, m_b;
  logic [OW-1:0] m_op;
  logic [1:0]    exp_rdy, exp_rv;
  logic [DW+3:0] m_exp;

  initial begin
    reset = 1'b1; req_valid = 2'b11; rsp_ready = 2'b11;
    req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    cyc(); cyc();
    // Reset state (reset still held with both requesters asking).
    #1;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_flags", rsp_flags, 0);
    chk("rst_count", op_count, 0);

    // Single add on requester 0.
    cyc();
    reset = 1'b0; req_valid = 2'b01; req0_a = 5; req0_b = 3; req0_op = 3'd0;
    #1 chk("add_req_ready", req_ready, 2'b01);
    cyc(); req_valid = 2'b00;
    #1 chk("add_exec_busy", busy, 1'b1);
    chk("add_exec_rsp_valid", rsp_valid, 2'b00);
    chk("add_alu_a", alu_a, 5); chk("add_alu_b", alu_b, 3); chk("add_alu_ctrl", alu_ctrl, 0);
    cyc();
    #1 chk("add_rsp_valid", rsp_valid, 2'b01);
    chk("add_result", rsp_result, 8); chk("add_flags", rsp_flags, 4'b0000);
    cyc();
    #1 chk("add_count", op_count, 1); chk("add_idle_busy", busy, 1'b0);
    chk("add_rsp_drop", rsp_valid, 2'b00);

    // Zero flag from requester 1 subtract.
    req_valid = 2'b10; req1_a = 7; req1_b = 7; req1_op = 3'd1;
    #1 chk("zero_req_ready", req_ready, 2'b10);
    cyc(); req_valid = 2'b00;
    cyc();
    #1 chk("zero_rsp_valid", rsp_valid, 2'b10);
    chk("zero_result", rsp_result, 0); chk("zero_zflag", rsp_flags[2], 1'b1);
    chk("zero_flags", rsp_flags, 4'b0110);
    cyc();
    #1 chk("zero_count", op_count, 2);

    // Round-robin from reset with both requesters held; also covers 2-bit counter wrap.
    reset = 1'b1; req_valid = 2'b11;
    req0_a = 32'h0F; req0_b = 32'hFF; req0_op = 3'd2;
    req1_a = 32'hF0; req1_b = 32'h0F; req1_op = 3'd3;
    cyc(); cyc();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1 chk("rr_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      cyc();
      #1 chk("rr_exec_ready", req_ready, 2'b00);
      cyc();
      #1 chk("rr_rsp_valid", rsp_valid, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("rr_result", rsp_result, (k % 2 == 0) ? 32'h0F : 32'hFF);
      chk("rr_resp_ready", req_ready, 2'b00);
      cyc();
      #1 chk("rr_count16", op_count, k + 1);
      chk("rr_count2", op_count2, (k + 1) % 4);
    end

    // Response backpressure on requester 0 while requester 1 waits.
    req_valid = 2'b01; rsp_ready = 2'b00;
    req0_a = 32'h12345678; req0_b = 32'hFFFFFFFF; req0_op = 3'd4;
    #1 chk("bp_req_ready0", req_ready, 2'b01);
    cyc();
    req_valid = 2'b10; req1_a = 100; req1_b = 58; req1_op = 3'd1;
    cyc();
    for (int i = 0; i < 5; i++) begin
      rsp_ready = (i == 2) ? 2'b10 : 2'b00;
      #1 chk("bp_rsp_valid", rsp_valid, 2'b01);
      chk("bp_result", rsp_result, 32'hEDCBA987);
      chk("bp_flags", rsp_flags, 4'b1000);
      chk("bp_req_ready", req_ready, 2'b00);
      chk("bp_busy", busy, 1'b1);
      cyc();
    end
    rsp_ready = 2'b01;
    #1 chk("bp_hs_rsp_valid", rsp_valid, 2'b01);
    chk("bp_hs_req_ready", req_ready, 2'b00);
    cyc();
    #1 chk("bp_req1_accept", req_ready, 2'b10);
    chk("bp_idle_rsp_valid", rsp_valid, 2'b00);
    cyc(); req_valid = 2'b00;
    cyc();
    #1 chk("bp_req1_rsp", rsp_valid, 2'b10);
    chk("bp_req1_result", rsp_result, 42);
    chk("bp_req1_flags", rsp_flags, 4'b0010);
    rsp_ready = 2'b11;
    cyc();
    #1 chk("bp_count", op_count, 7);

    // Reset asserted in the EXEC cycle of an xor.
    req_valid = 2'b01; req0_a = 32'hAAAA5555; req0_b = 32'hFFFF0000; req0_op = 3'd4;
    #1 chk("rmo_req_ready", req_ready, 2'b01);
    cyc();
    req_valid = 2'b00; reset = 1'b1;
    #1 chk("rmo_exec_busy", busy, 1'b1);
    cyc();
    reset = 1'b0;
    #1 chk("rmo_busy", busy, 1'b0);
    chk("rmo_alu_a", alu_a, 0); chk("rmo_alu_b", alu_b, 0); chk("rmo_alu_ctrl", alu_ctrl, 0);
    chk("rmo_count", op_count, 0); chk("rmo_result", rsp_result, 0);
    for (int i = 0; i < 4; i++) begin
      chk("rmo_no_rsp", rsp_valid, 2'b00);
      cyc();
    end

    // Random traffic against a transaction-level reference.
    m_busy = 1'b0; m_age = 0; m_owner = 1'b0; m_last = 1'b1; m_cnt = 0;
    m_a = '0; m_b = '0; m_op = '0;
    for (int c = 0; c < 800; c++) begin
      req_valid = 2'($urandom_range(0, 3));
      rsp_ready = 2'($urandom_range(0, 3));
      req0_a = $urandom; req0_b = $urandom; req0_op = 3'($urandom_range(0, 7));
      req1_a = $urandom; req1_b = $urandom; req1_op = 3'($urandom_range(0, 7));
      if (c % 7 == 0) req0_b = req0_a;
      #1;
      // Only an idle arbiter grants; on contention the requester not served last wins.
      exp_rdy = 2'b00;
      if (!m_busy) begin
        if (req_valid == 2'b01)      exp_rdy = 2'b01;
        else if (req_valid == 2'b10) exp_rdy = 2'b10;
        else if (req_valid == 2'b11) exp_rdy = (m_last == 1'b0) ? 2'b10 : 2'b01;
      end
      exp_rv = 2'b00;
      if (m_busy && m_age >= 2) exp_rv = m_owner ? 2'b10 : 2'b01;
      m_exp = alu_f(m_a, m_b, m_op);
      chk("rnd_req_ready", req_ready, exp_rdy);
      chk("rnd_busy", busy, m_busy);
      chk("rnd_rsp_valid", rsp_valid, exp_rv);
      if (exp_rv != 2'b00) begin
        chk("rnd_result", rsp_result, m_exp[DW+3:4]);
        chk("rnd_flags", rsp_flags, m_exp[3:0]);
      end
      chk("rnd_count16", op_count, m_cnt % 65536);
      chk("rnd_count2", op_count2, m_cnt % 4);
      chk("rnd_alu_a", alu_a, m_a);
      chk("rnd_alu_b", alu_b, m_b);
      chk("rnd_alu_ctrl", alu_ctrl, m_op);
      if (!m_busy) begin
        if (exp_rdy != 2'b00) begin
          m_busy  = 1'b1;
          m_age   = 1;
          m_owner = exp_rdy[1];
          m_a     = exp_rdy[1] ? req1_a  : req0_a;
          m_b     = exp_rdy[1] ? req1_b  : req0_b;
          m_op    = exp_rdy[1] ? req1_op : req0_op;
        end
      end else if (m_age >= 2 && rsp_ready[m_owner]) begin
        m_busy = 1'b0;
        m_last = m_owner;
        m_cnt  = m_cnt + 1;
      end else begin
        m_age = m_age + 1;
      end
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
